pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
- Parametrised successor to the single-cycle program counter: holds the architectural PC and selects the next PC from trap, jump, branch, return prediction or sequential flow.
- Adds pipeline stall, trap redirect, misaligned-target fault detection and a RAS_DEPTH-entry return-address stack (push on call, pop on return).
- Sits at the head of the fetch path; outputPCAddress drives instruction memory.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment; also the alignment requirement (power of two, ≥2).
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- stall  in  1  hold PC and RAS this cycle
- trap_enable  in  1  redirect to trap_vector; overrides stall
- trap_vector  in  XLEN  trap handler address
- jump_enable  in  1  take jump_target_address
- jump_target_address  in  XLEN  jump target
- ras_push  in  1  with jump_enable: push PC+INSTR_BYTES (call)
- branEnable  in  1  take branAddress
- branAddress  in  XLEN  branch target
- ras_pop  in  1  return: next PC = RAS top
- outputPCAddress  out  XLEN  current PC (registered)
- pc_plus_inc  out  XLEN  outputPCAddress + INSTR_BYTES (combinational)
- misaligned_fault  out  1  registered one-cycle pulse: selected target was misaligned
- fault_addr  out  XLEN  last misaligned target (registered, holds)
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_underflow  out  1  registered one-cycle pulse: pop on empty RAS

Behaviour:
- Reset (reset_n low at rising clk edge): outputPCAddress=RESET_VECTOR, ras_count=0, misaligned_fault=0, ras_underflow=0, fault_addr=0. RAS storage contents are don't-care. Reset overrides all other inputs, including mid-stall and mid-trap.
- Next-PC priority, evaluated each cycle: trap_enable > stall > jump_enable > branEnable > ras_pop > sequential (PC+INSTR_BYTES).
- PC update latency is one cycle: the selected value appears on outputPCAddress after the next rising edge.
- Trap: PC←trap_vector regardless of stall or any other request. RAS is unchanged. trap_vector is not alignment-checked.
- Stall without trap: PC, RAS, pointer and count all hold; push/pop ignored; fault pulses deassert.
- Jump: PC←jump_target_address.
  - If ras_push: push the current PC+INSTR_BYTES.
  - When full, the push overwrites the oldest entry (circular) and ras_count saturates at RAS_DEPTH.
  - ras_pop is ignored on a jump cycle.
- Branch (no jump): PC←branAddress; push and pop ignored.
- Pop (no jump/branch):
  - RAS non-empty: PC←top entry, pointer decrements, ras_count−1.
  - RAS empty: PC←PC+INSTR_BYTES and ras_underflow pulses the next cycle.
- Misalignment: a jump, branch or pop target with address bits [log2(INSTR_BYTES)−1:0] ≠ 0 does not load.
  - PC holds its current value.
  - misaligned_fault pulses for one cycle and fault_addr captures the target.
  - An associated RAS push or pop is still performed.
- Arithmetic: all additions are modulo 2^XLEN; PC=all-ones−(INSTR_BYTES−1) wraps to 0.
- Simultaneous push+pop is only possible with jump_enable; push wins, pop is discarded.

Test Plan:
- Reset then 3 free-running cycles, RESET_VECTOR=0x100 -> PC 0x100, 0x104, 0x108, 0x10C; ras_count=0.
- At PC 0x200: jump_enable+ras_push to 0x800; next cycle ras_pop -> PC 0x800 then 0x204; ras_count 1 then 0.
- Five calls from 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4), then five pops -> returns 0x54, 0x44, 0x34, 0x24; fifth pop gives PC+4 with ras_underflow=1; ras_count peaks at 4.
- Branch to 0x302 -> PC holds, misaligned_fault=1 for 1 cycle, fault_addr=0x302; jump+branch together to 0x400/0x500 -> PC 0x400.
- stall=1 for 3 cycles at PC 0x40 with jump_enable asserted -> PC stays 0x40, RAS unchanged; trap_enable during the stall with trap_vector=0x1000 -> PC 0x1000.
- PC=0xFFFF_FFFC sequential -> 0x0000_0000; reset_n low during a stall with RAS count 2 -> PC=RESET_VECTOR, ras_count=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with trap redirect, stall, misaligned-target
// fault detection and a circular return-address stack.
// Next-PC priority: trap > stall > jump > branch > RAS pop > sequential.
module pc_unit_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic                         trap_enable,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         jump_enable,
  input  logic [XLEN-1:0]              jump_target_address,
  input  logic                         ras_push,
  input  logic                         branEnable,
  input  logic [XLEN-1:0]              branAddress,
  input  logic                         ras_pop,
  output logic [XLEN-1:0]              outputPCAddress,
  output logic [XLEN-1:0]              pc_plus_inc,
  output logic                         misaligned_fault,
  output logic [XLEN-1:0]              fault_addr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ALIGN_W = $clog2(INSTR_BYTES);
  localparam logic [XLEN-1:0]  INC      = XLEN'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;          // index of the top entry
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
  logic             underflow_q, underflow_d;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [XLEN-1:0]  ras_top;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  target;
  logic             target_valid;
  logic             push_en;

  assign pc_seq  = pc_q + INC;
  assign ras_top = ras_mem[ptr_q];

  // Select next PC, RAS pointer/count movement and fault/underflow pulses.
  always_comb begin
    pc_d         = pc_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    underflow_d  = 1'b0;
    push_en      = 1'b0;
    target       = '0;
    target_valid = 1'b0;

    if (trap_enable) begin
      // Trap vector is taken as-is, no alignment check, RAS untouched.
      pc_d = trap_vector;
    end else if (!stall) begin
      if (jump_enable) begin
        target       = jump_target_address;
        target_valid = 1'b1;
        // A call pushes the return address; a pop on the same cycle is dropped.
        if (ras_push) begin
          push_en = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end else if (branEnable) begin
        target       = branAddress;
        target_valid = 1'b1;
      end else if (ras_pop) begin
        if (cnt_q != '0) begin
          target       = ras_top;
          target_valid = 1'b1;
          ptr_d        = ptr_q - PTR_W'(1);
          cnt_d        = cnt_q - CNT_W'(1);
        end else begin
          underflow_d = 1'b1;
          pc_d        = pc_seq;
        end
      end else begin
        pc_d = pc_seq;
      end

      // A misaligned target is not loaded; the PC holds and the fault is logged.
      if (target_valid) begin
        if (|target[ALIGN_W-1:0]) begin
          fault_d      = 1'b1;
          fault_addr_d = target;
        end else begin
          pc_d = target;
        end
      end
    end
  end

  // Architectural state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      ptr_q        <= '0;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      underflow_q  <= underflow_d;
    end
  end

  // RAS storage: write the return address into the slot above the old top.
  always_ff @(posedge clk) begin
    if (reset_n && push_en) begin
      ras_mem[ptr_d] <= pc_seq;
    end
  end

  assign outputPCAddress  = pc_q;
  assign pc_plus_inc      = pc_seq;
  assign misaligned_fault = fault_q;
  assign fault_addr       = fault_addr_q;
  assign ras_count        = cnt_q;
  assign ras_underflow    = underflow_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed walk through the key scenarios followed by random
// stimulus, every cycle compared against a queue-based behavioural model.
module tb_pc_unit_ras;

  localparam int unsigned     XLEN  = 32;
  localparam logic [31:0]     RV    = 32'h0000_0100;
  localparam int unsigned     DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, stall, trap_enable, jump_enable, ras_push, branEnable, ras_pop;
  logic [31:0] trap_vector, jump_target_address, branAddress;
  logic [31:0] outputPCAddress, pc_plus_inc, fault_addr;
  logic        misaligned_fault, ras_underflow;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_fault, m_uf;
  logic [31:0] m_faddr;

  pc_unit_ras #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .trap_enable(trap_enable), .trap_vector(trap_vector),
    .jump_enable(jump_enable), .jump_target_address(jump_target_address),
    .ras_push(ras_push), .branEnable(branEnable), .branAddress(branAddress),
    .ras_pop(ras_pop), .outputPCAddress(outputPCAddress), .pc_plus_inc(pc_plus_inc),
    .misaligned_fault(misaligned_fault), .fault_addr(fault_addr),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply model rules for one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] t;
    logic        have_t;
    have_t = 1'b0;
    t      = '0;
    if (!reset_n) begin
      m_pc = RV; m_stack.delete(); m_fault = 0; m_uf = 0; m_faddr = 0;
    end else if (trap_enable) begin
      m_pc = trap_vector; m_fault = 0; m_uf = 0;
    end else if (stall) begin
      m_fault = 0; m_uf = 0;
    end else begin
      m_fault = 0; m_uf = 0;
      if (jump_enable) begin
        t = jump_target_address; have_t = 1;
        if (ras_push) begin
          m_stack.push_back(m_pc + 32'd4);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
        end
      end else if (branEnable) begin
        t = branAddress; have_t = 1;
      end else if (ras_pop) begin
        if (m_stack.size() > 0) begin
          t = m_stack.pop_back(); have_t = 1;
        end else begin
          m_uf = 1; m_pc = m_pc + 32'd4;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (have_t) begin
        if (t[1:0] != 2'b00) begin
          m_fault = 1; m_faddr = t;
        end else begin
          m_pc = t;
        end
      end
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic tr, input logic [31:0] tv,
                      input logic jp, input logic [31:0] ja, input logic ps,
                      input logic br, input logic [31:0] ba, input logic pp);
    reset_n = rn; stall = st; trap_enable = tr; trap_vector = tv;
    jump_enable = jp; jump_target_address = ja; ras_push = ps;
    branEnable = br; branAddress = ba; ras_pop = pp;
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t rn=%b st=%b tr=%b jp=%b ps=%b br=%b pp=%b -> pc=%h cnt=%0d flt=%b fa=%h uf=%b",
             $time, rn, st, tr, jp, ps, br, pp, outputPCAddress, ras_count,
             misaligned_fault, fault_addr, ras_underflow);
    check_eq("pc", outputPCAddress, m_pc);
    check_eq("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
    check_eq("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, m_fault});
    check_eq("fault_addr", fault_addr, m_faddr);
    check_eq("ras_count", {29'd0, ras_count}, 32'(m_stack.size()));
    check_eq("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_uf});
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [31:0] a, input logic push);
    step(1, 0, 0, 0, 1, a, push, 0, 0, 0);
  endtask

  task automatic pop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | ($urandom & 32'hC);
    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    // Reset and free-running sequential flow
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("tp_reset_pc", outputPCAddress, 32'h100);
    check_eq("tp_reset_cnt", {29'd0, ras_count}, 32'd0);
    idle(); check_eq("tp_seq1", outputPCAddress, 32'h104);
    idle(); check_eq("tp_seq2", outputPCAddress, 32'h108);
    idle(); check_eq("tp_seq3", outputPCAddress, 32'h10C);

    // Single call and return
    jump(32'h200, 0);
    jump(32'h800, 1);
    check_eq("tp_call_pc", outputPCAddress, 32'h800);
    check_eq("tp_call_cnt", {29'd0, ras_count}, 32'd1);
    pop();
    check_eq("tp_ret_pc", outputPCAddress, 32'h204);
    check_eq("tp_ret_cnt", {29'd0, ras_count}, 32'd0);

    // Five nested calls overflow a 4-deep stack, then five returns
    jump(32'h10, 0);
    for (int i = 1; i <= 5; i++) jump((i < 5) ? 32'(32'h10 * (i + 1)) : 32'h900, 1);
    check_eq("tp_ras_full", {29'd0, ras_count}, 32'd4);
    pop(); check_eq("tp_pop1", outputPCAddress, 32'h54);
    pop(); check_eq("tp_pop2", outputPCAddress, 32'h44);
    pop(); check_eq("tp_pop3", outputPCAddress, 32'h34);
    pop(); check_eq("tp_pop4", outputPCAddress, 32'h24);
    pop();
    check_eq("tp_pop5_pc", outputPCAddress, 32'h28);
    check_eq("tp_underflow", {31'd0, ras_underflow}, 32'd1);

    // Misaligned branch, then jump beating branch
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h302, 0);
    check_eq("tp_mis_pc", outputPCAddress, 32'h28);
    check_eq("tp_mis_flt", {31'd0, misaligned_fault}, 32'd1);
    check_eq("tp_mis_addr", fault_addr, 32'h302);
    idle();
    check_eq("tp_mis_clear", {31'd0, misaligned_fault}, 32'd0);
    check_eq("tp_mis_hold", fault_addr, 32'h302);
    step(1, 0, 0, 0, 1, 32'h400, 0, 1, 32'h500, 0);
    check_eq("tp_jmp_over_br", outputPCAddress, 32'h400);

    // Stall holds PC and RAS; trap overrides stall
    jump(32'h40, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 32'h800, 1, 0, 0, 0);
    check_eq("tp_stall_pc", outputPCAddress, 32'h40);
    check_eq("tp_stall_cnt", {29'd0, ras_count}, 32'd1);
    step(1, 1, 1, 32'h1000, 1, 32'h800, 1, 0, 0, 0);
    check_eq("tp_trap_pc", outputPCAddress, 32'h1000);
    check_eq("tp_trap_cnt", {29'd0, ras_count}, 32'd1);

    // Wrap at top of address space; reset during a stall
    jump(32'hFFFF_FFFC, 0);
    idle();
    check_eq("tp_wrap", outputPCAddress, 32'h0);
    jump(32'h80, 1);
    check_eq("tp_cnt2", {29'd0, ras_count}, 32'd2);
    step(0, 1, 0, 0, 1, 32'h800, 1, 0, 0, 0);
    check_eq("tp_rst_stall_pc", outputPCAddress, RV);
    check_eq("tp_rst_stall_cnt", {29'd0, ras_count}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, rand_addr(),
           $urandom_range(0, 3) == 0, rand_addr(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4) == 0, rand_addr(),
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
